// File: rtl/rm_lane_event_scheduler.sv
// rtl/rm_lane_event_scheduler.sv - sticky per-lane event capture and round-robin issue onto one event port
// Pending bits are cleared when their event is loaded into the output register.
module rm_lane_event_scheduler #(
   parameter  int NUM_LANES  = 5,
   parameter  int NUM_EVENTS = 10,
   parameter  int CNT_W      = 8,
   localparam int LANE_W     = (NUM_LANES  > 1) ? $clog2(NUM_LANES)  : 1,
   localparam int EVT_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  enable_i,
   input  logic [NUM_LANES-1:0][NUM_EVENTS-1:0]  lane_vector_i,
   input  logic [NUM_LANES-1:0]                  lane_reset_i,
   output logic                                  evt_valid_o,
   input  logic                                  evt_ready_i,
   output logic [LANE_W-1:0]                     evt_lane_o,
   output logic [EVT_W-1:0]                      evt_id_o,
   output logic [NUM_LANES-1:0][NUM_EVENTS-1:0]  pending_o,
   output logic [NUM_LANES-1:0][CNT_W-1:0]       drop_cnt_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t                                r_state;
   state_t                                w_state_nxt;
   logic [NUM_LANES-1:0][NUM_EVENTS-1:0]  r_pending;
   logic [NUM_LANES-1:0][CNT_W-1:0]       r_drop_cnt;
   logic [LANE_W-1:0]                     r_rr_ptr;
   logic [LANE_W-1:0]                     r_lane;
   logic [EVT_W-1:0]                      r_id;

   logic                                  w_any;
   logic                                  w_load;
   logic                                  w_found;
   logic [LANE_W-1:0]                     w_grant_lane;
   logic [NUM_EVENTS-1:0]                 w_grant_vec;
   logic [EVT_W-1:0]                      w_grant_id;
   logic [LANE_W-1:0]                     w_rr_next;
   logic [NUM_LANES-1:0][NUM_EVENTS-1:0]  w_issue_mask;

   assign w_any  = |r_pending;
   assign w_load = ((r_state == S_IDLE) || evt_ready_i) && enable_i && w_any;

   // Two ascending passes: lanes at/after the pointer first, then the wrapped lanes below it.
   always_comb begin
      w_found      = 1'b0;
      w_grant_lane = '0;
      w_grant_vec  = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (!w_found && (LANE_W'(l) >= r_rr_ptr) && (|r_pending[l])) begin
            w_found      = 1'b1;
            w_grant_lane = LANE_W'(l);
            w_grant_vec  = r_pending[l];
         end
      end
      for (int l = 0; l < NUM_LANES; l++) begin
         if (!w_found && (LANE_W'(l) < r_rr_ptr) && (|r_pending[l])) begin
            w_found      = 1'b1;
            w_grant_lane = LANE_W'(l);
            w_grant_vec  = r_pending[l];
         end
      end
   end

   always_comb begin
      w_grant_id = '0;
      for (int e = NUM_EVENTS - 1; e >= 0; e--) begin
         if (w_grant_vec[e]) begin
            w_grant_id = EVT_W'(e);
         end
      end
   end

   assign w_rr_next = (w_grant_lane == LANE_W'(NUM_LANES - 1)) ? '0 : w_grant_lane + LANE_W'(1);

   always_comb begin
      w_issue_mask = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         for (int e = 0; e < NUM_EVENTS; e++) begin
            w_issue_mask[l][e] = w_load && (w_grant_lane == LANE_W'(l)) && (w_grant_id == EVT_W'(e));
         end
      end
   end

   // A re-strobe of the issuing bit re-arms it and is not a collision, since the mask removes it first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pending  <= '0;
         r_drop_cnt <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_reset_i[l]) begin
               r_pending[l]  <= '0;
               r_drop_cnt[l] <= '0;
            end else begin
               r_pending[l] <= (r_pending[l] & ~w_issue_mask[l]) | lane_vector_i[l];
               if ((|(lane_vector_i[l] & r_pending[l] & ~w_issue_mask[l])) &&
                   (r_drop_cnt[l] != {CNT_W{1'b1}})) begin
                  r_drop_cnt[l] <= r_drop_cnt[l] + CNT_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr <= '0;
         r_lane   <= '0;
         r_id     <= '0;
      end else if (w_load) begin
         r_rr_ptr <= w_rr_next;
         r_lane   <= w_grant_lane;
         r_id     <= w_grant_id;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_load) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (evt_ready_i && !w_load) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign evt_valid_o = (r_state == S_HOLD);
   assign evt_lane_o  = r_lane;
   assign evt_id_o    = r_id;
   assign pending_o   = r_pending;
   assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_rm_lane_event_scheduler.sv
// tb/tb_rm_lane_event_scheduler.sv - directed and random checks of the lane event scheduler
module tb_rm_lane_event_scheduler;

   localparam int NL   = 5;
   localparam int NE   = 10;
   localparam int CW   = 2;
   localparam int CMAX = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 ready;
   logic [NL-1:0][NE-1:0] vec;
   logic [NL-1:0]        lrst;
   logic                 valid;
   logic [2:0]           lane;
   logic [3:0]           id;
   logic [NL-1:0][NE-1:0] pend;
   logic [NL-1:0][CW-1:0] cnt;

   int total = 0;
   int bad   = 0;

   bit [NE-1:0] m_pend [NL];
   int          m_cnt  [NL];
   int          m_rr;
   bit          m_valid;
   int          m_lane;
   int          m_id;

   rm_lane_event_scheduler #(.NUM_LANES(NL), .NUM_EVENTS(NE), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (en),
      .lane_vector_i (vec),
      .lane_reset_i  (lrst),
      .evt_valid_o   (valid),
      .evt_ready_i   (ready),
      .evt_lane_o    (lane),
      .evt_id_o      (id),
      .pending_o     (pend),
      .drop_cnt_o    (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: one edge of the scheduler described as sticky sets, a rotating search and a held slot.
   task automatic model_step();
      bit          any;
      bit          ld;
      int          gl;
      int          gid;
      bit [NE-1:0] mask;
      if (rst) begin
         for (int l = 0; l < NL; l++) begin
            m_pend[l] = '0;
            m_cnt[l]  = 0;
         end
         m_rr = 0; m_valid = 0; m_lane = 0; m_id = 0;
      end else begin
         any = 0;
         for (int l = 0; l < NL; l++) any |= (m_pend[l] != 0);
         ld  = (!m_valid || ready) && en && any;
         gl  = -1;
         gid = 0;
         if (ld) begin
            for (int k = 0; k < NL; k++) begin
               if (gl < 0 && m_pend[(m_rr + k) % NL] != 0) gl = (m_rr + k) % NL;
            end
            for (int e = NE - 1; e >= 0; e--) begin
               if (m_pend[gl][e]) gid = e;
            end
         end
         for (int l = 0; l < NL; l++) begin
            mask = (ld && l == gl) ? (NE'(1) << gid) : '0;
            if (lrst[l]) begin
               m_pend[l] = '0;
               m_cnt[l]  = 0;
            end else begin
               if ((vec[l] & m_pend[l] & ~mask) != 0 && m_cnt[l] < CMAX) m_cnt[l]++;
               m_pend[l] = (m_pend[l] & ~mask) | vec[l];
            end
         end
         if (ld) begin
            m_valid = 1; m_lane = gl; m_id = gid; m_rr = (gl + 1) % NL;
         end else if (m_valid && ready) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic cycle();
      logic [NL-1:0][NE-1:0] ep;
      logic [NL-1:0][CW-1:0] ec;
      model_step();
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
         ep[l] = m_pend[l];
         ec[l] = CW'(m_cnt[l]);
      end
      chk("model_valid", valid, m_valid);
      if (m_valid) begin
         chk("model_lane", lane, m_lane);
         chk("model_id", id, m_id);
      end
      chk("model_pending", pend, ep);
      chk("model_drop_cnt", cnt, ec);
   endtask

   int exp_order [3] = '{0, 1, 4};
   logic [2:0] held_lane;
   logic [3:0] held_id;

   initial begin
      rst = 1; en = 1; ready = 1; vec = '0; lrst = '0;
      cycle();
      rst = 0; en = 0;
      vec[0] = 10'h011; vec[3] = 10'h200;
      cycle();
      vec = '0; rst = 1;
      cycle();
      chk("reset_pending", pend, 0);
      chk("reset_drop_cnt", cnt, 0);
      chk("reset_valid", valid, 0);
      rst = 0; en = 1;

      vec[2] = 10'b0000001000;
      cycle();
      vec = '0;
      cycle();
      chk("single_valid", valid, 1);
      chk("single_lane", lane, 2);
      chk("single_id", id, 3);
      chk("single_pending", pend, 0);
      cycle();
      chk("single_one_cycle", valid, 0);

      rst = 1;
      cycle();
      rst = 0;
      vec[0] = 10'h001; vec[1] = 10'h001; vec[4] = 10'h001;
      cycle();
      vec = '0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rr_valid", valid, 1);
         chk("rr_lane", lane, exp_order[i]);
         chk("rr_id", id, 0);
      end
      cycle();
      chk("rr_drained", valid, 0);
      vec[0] = 10'h001; vec[3] = 10'h001;
      cycle();
      vec = '0;
      cycle();
      chk("rr_restart_lane", lane, 0);
      cycle();
      chk("rr_second_lane", lane, 3);
      cycle();

      ready = 0;
      vec[1] = 10'h080; vec[3] = 10'h004;
      cycle();
      vec = '0;
      cycle();
      held_lane = lane;
      held_id   = id;
      for (int i = 0; i < 5; i++) begin
         vec[0] = NE'(1) << i;
         cycle();
         chk("bp_valid", valid, 1);
         chk("bp_lane_stable", lane, held_lane);
         chk("bp_id_stable", id, held_id);
      end
      vec = '0; ready = 1;
      for (int i = 0; i < 10; i++) cycle();
      chk("bp_no_loss", pend, 0);

      rst = 1;
      cycle();
      rst = 0; en = 0;
      vec[1] = 10'h020;
      cycle();
      for (int i = 0; i < 6; i++) cycle();
      chk("sat_drop_cnt", cnt[1], CMAX);
      vec = '0; lrst[1] = 1;
      cycle();
      chk("lrst_drop_cnt", cnt[1], 0);
      chk("lrst_pending", pend[1], 0);

      en = 1; lrst = '0; lrst[3] = 1; vec[3] = 10'h3FF;
      cycle();
      chk("simul_lrst_pending", pend[3], 0);
      lrst = '0; vec = '0;
      cycle();
      vec[2] = 10'h010;
      cycle();
      cycle();
      chk("rearm_pending", pend[2], 10'h010);
      chk("rearm_no_drop", cnt[2], 0);
      chk("rearm_valid", valid, 1);
      chk("rearm_lane", lane, 2);
      chk("rearm_id", id, 4);
      vec = '0;
      for (int i = 0; i < 4; i++) cycle();

      for (int c = 0; c < 800; c++) begin
         rst   = ($urandom_range(0, 149) == 0);
         en    = ($urandom_range(0, 9) != 0);
         ready = ($urandom_range(0, 2) != 0);
         for (int l = 0; l < NL; l++) begin
            lrst[l] = ($urandom_range(0, 39) == 0);
            vec[l]  = '0;
            if ($urandom_range(0, 3) == 0) vec[l] = NE'(1) << $urandom_range(0, NE - 1);
            if ($urandom_range(0, 9) == 0) vec[l] = vec[l] | (NE'(1) << $urandom_range(0, NE - 1));
         end
         cycle();
      end

      rst = 0; lrst = '0; vec = '0; en = 1; ready = 1;
      for (int i = 0; i < 60; i++) cycle();
      chk("final_drained", pend, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
